unary_mac_accum: RTL and testbench
==================================

# unary_mac_accum

Downstream reduction stage for `unary_binary_MAC`: consumes the MAC's `out` each time its `ready` rises, sums `LEN` consecutive MAC results into a wider accumulator, and offers the completed dot-product sum to the next stage over a valid/ready handshake. It holds one early-arriving result in a single-entry pending buffer while a finished sum waits to be taken, so the MAC never has to stall.

## Interface

Parameters:
- `IN_W`, default 8: MAC result width (2×MAC operand width).
- `ACC_W`, default 12: accumulator and sum width; must satisfy `ACC_W ≥ IN_W`.
- `LEN`, default 4: MAC results per sum; must satisfy `LEN ≥ 2`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mac_ready`  in  1  MAC `ready` level; a 0→1 transition marks a new result.
- `mac_out`  in  IN_W  MAC `out`, sampled on the cycle a rise is detected.
- `clear`  in  1  abandons the current accumulation.
- `sum_ready`  in  1  downstream accepts `sum`.
- `sum_valid`  out  1  `sum` is complete.
- `sum`  out  ACC_W  accumulated result.
- `overflow`  out  1  accumulation of the presented or in-progress sum exceeded `ACC_W`.
- `count`  out  $clog2(LEN+1)  results in the current accumulation.
- `lost`  out  1  sticky: a result was dropped.

## Operation

- Edge detect: `mac_ready_q` register, reset 0; `rise = mac_ready & ~mac_ready_q`. A level held high counts once.
- States:
  - ACCUM: on `rise`, `acc <= acc + mac_out` (zero-extended) and `count <= count+1`. If the new count equals `LEN`, go to HOLD.
  - HOLD: `sum_valid = 1`, `sum = acc`, `acc` frozen.
- In HOLD, a `rise` with the pending buffer empty stores `mac_out` in `pend` and sets `pend_v`.
- In HOLD, a `rise` with `pend_v` already set drops the result and sets `lost`.
- Handshake `sum_valid & sum_ready`: return to ACCUM.
  - `acc` reloads with (`pend_v ? pend : 0`) plus (`rise ? mac_out : 0`).
  - `count` reloads with the number of terms just loaded (0–2).
  - `pend_v` clears and `overflow` recomputes from the reload.
  - If the reloaded count equals `LEN`, go to HOLD on the next edge.
- `overflow`:
  - Set on any add whose true sum exceeds 2^ACC_W−1.
  - Stays set while the sum is held.
  - Cleared on handshake reload, `clear` and `reset`.
- `clear` has priority over all but `reset`:
  - `acc`, `count`, `pend_v` and `overflow` go to 0; state goes to ACCUM; `sum_valid` goes to 0.
  - A `rise` in the same cycle is discarded, but `mac_ready_q` still updates.
  - `lost` is cleared.
- Reset values: `sum_valid` 0, `sum` 0, `overflow` 0, `count` 0, `lost` 0, `mac_ready_q` 0, `pend_v` 0, state ACCUM. Reset mid-accumulation or mid-HOLD discards everything.

## Timing

- A `rise` detected at edge k updates `acc` and `count`, visible after k.
- If that rise completes `LEN` terms, `sum_valid` is 1 in the cycle after k.
- Best-case latency from the `LEN`-th MAC `ready` rise to `sum_valid`: 1 cycle.
- Throughput: one sum per `LEN` MAC results, with no bubbles, provided `sum_ready` returns before a second result arrives in HOLD.
- `sum` and `overflow` are stable while `sum_valid` is high and `sum_ready` is low.
- `sum_valid` drops the cycle after the handshake, unless the reload completes `LEN` terms.
- `mac_out` is sampled only in the `rise` cycle.

## Configuration

- `UNARY_ACC_SAT_EN` defined: on overflow, `acc` clamps to 2^ACC_W−1 and stays there for the rest of that accumulation; `overflow` is still flagged.
- Undefined: `acc` wraps modulo 2^ACC_W; `overflow` is flagged.

## Test plan

- Basic sum: `LEN`=4, `ACC_W`=12. Four `mac_ready` pulses with `mac_out`=240 → `sum_valid`=1 one cycle after the 4th rise, `sum`=960, `overflow`=0, `count`=4; `sum_ready`=1 → `sum_valid`=0 and `count`=0 next cycle.
- Level hold: `mac_ready` held high 20 cycles with `mac_out`=240 → exactly one term counted (`count`=1, `acc`=240).
- Overflow: `ACC_W`=9, four results of 240.
  - Macro undefined → `sum`=448, `overflow`=1.
  - `UNARY_ACC_SAT_EN` defined → `sum`=511, `overflow`=1.
- Backpressure:
  - `sum_ready`=0 while a 5th result (`mac_out`=15) arrives → `sum` stays 960; after handshake `count`=1, `acc`=15.
  - With `pend_v` already set, a 6th result arrives → `lost`=1.
- Simultaneous: `pend_v` set (value 15), and a `rise` with `mac_out`=225 coincides with the handshake → `count`=2, `acc`=240.
- Clear/reset mid-operation: after 2 terms, `clear`=1 together with a `rise` → `count`=0, `acc`=0, rise ignored. Repeat with `reset`=1 in HOLD → all outputs 0 the next cycle.

Source files
------------

// File: rtl/unary_mac_accum.sv
// Reduction stage after unary_binary_MAC: sums LEN results per MAC ready rise and
// offers the sum over valid/ready. Define UNARY_ACC_SAT_EN to saturate instead of wrap.
module unary_mac_accum #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12,
  parameter int LEN   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mac_ready,
  input  logic [IN_W-1:0]            mac_out,
  input  logic                       clear,
  input  logic                       sum_ready,
  output logic                       sum_valid,
  output logic [ACC_W-1:0]           sum,
  output logic                       overflow,
  output logic [$clog2(LEN+1)-1:0]   count,
  output logic                       lost
);

  localparam int CW = $clog2(LEN + 1);

  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state;

  logic            mac_ready_q;
  logic            rise;
  logic [IN_W-1:0] pend;
  logic            pend_v;
  logic [ACC_W:0]  ext_in;
  logic [ACC_W:0]  add_full;
  logic [ACC_W:0]  reload_full;
  logic [CW-1:0]   reload_n;

  // The carry bit of each (ACC_W+1)-bit sum is the overflow indication.
  function automatic logic [ACC_W-1:0] fit(input logic [ACC_W:0] full);
`ifdef UNARY_ACC_SAT_EN
    return full[ACC_W] ? '1 : full[ACC_W-1:0];
`else
    return full[ACC_W-1:0];
`endif
  endfunction

  always_comb begin
    rise        = mac_ready & ~mac_ready_q;
    ext_in      = (ACC_W+1)'(mac_out);
    add_full    = {1'b0, sum} + ext_in;
    reload_full = (pend_v ? (ACC_W+1)'(pend) : '0) + (rise ? ext_in : '0);
    reload_n    = CW'(pend_v) + CW'(rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      mac_ready_q <= 1'b0;
      sum         <= '0;
      sum_valid   <= 1'b0;
      overflow    <= 1'b0;
      count       <= '0;
      lost        <= 1'b0;
      pend        <= '0;
      pend_v      <= 1'b0;
    end else begin
      mac_ready_q <= mac_ready;
      if (clear) begin
        state     <= ACCUM;
        sum       <= '0;
        sum_valid <= 1'b0;
        overflow  <= 1'b0;
        count     <= '0;
        lost      <= 1'b0;
        pend_v    <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (rise) begin
              sum      <= fit(add_full);
              overflow <= overflow | add_full[ACC_W];
              count    <= count + CW'(1);
              if (count == CW'(LEN - 1)) begin
                state     <= HOLD;
                sum_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (sum_ready) begin
              // A rise coinciding with the handshake joins the reloaded accumulation.
              sum      <= fit(reload_full);
              overflow <= reload_full[ACC_W];
              count    <= reload_n;
              pend_v   <= 1'b0;
              if (reload_n == CW'(LEN)) begin
                state     <= HOLD;
                sum_valid <= 1'b1;
              end else begin
                state     <= ACCUM;
                sum_valid <= 1'b0;
              end
            end else if (rise) begin
              if (!pend_v) begin
                pend   <= mac_out;
                pend_v <= 1'b1;
              end else begin
                lost <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unary_mac_accum.sv
// Self-checking bench for unary_mac_accum: a 12-bit and a 9-bit accumulator share stimulus
// and are compared every cycle against a term-list reference model.
module tb_unary_mac_accum;

`ifdef UNARY_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mac_ready = 1'b0;
  logic [7:0] mac_out = '0;
  logic       clear = 1'b0;
  logic       sum_ready = 1'b0;

  logic        valid_a, ovf_a, lost_a;
  logic [11:0] sum_a;
  logic [2:0]  cnt_a;
  logic        valid_b, ovf_b, lost_b;
  logic [8:0]  sum_b;
  logic [2:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  // Reference model: the current accumulation is a list of terms.
  int unsigned terms[$];
  bit          m_valid = 0;
  bit          m_has_pend = 0;
  int unsigned m_pend = 0;
  bit          m_lost = 0;
  bit          m_prev = 0;

  always #5 clk = ~clk;

  unary_mac_accum #(.IN_W(8), .ACC_W(12), .LEN(LEN)) dut_a (
    .clk(clk), .reset(reset), .mac_ready(mac_ready), .mac_out(mac_out),
    .clear(clear), .sum_ready(sum_ready), .sum_valid(valid_a), .sum(sum_a),
    .overflow(ovf_a), .count(cnt_a), .lost(lost_a)
  );

  unary_mac_accum #(.IN_W(8), .ACC_W(9), .LEN(LEN)) dut_b (
    .clk(clk), .reset(reset), .mac_ready(mac_ready), .mac_out(mac_out),
    .clear(clear), .sum_ready(sum_ready), .sum_valid(valid_b), .sum(sum_b),
    .overflow(ovf_b), .count(cnt_b), .lost(lost_b)
  );

  function automatic void fold(input int w, output longint unsigned s, output bit o);
    longint unsigned mx = (longint'(1) << w) - 1;
    s = 0;
    o = 0;
    foreach (terms[i]) begin
      longint unsigned t = s + terms[i];
      if (t > mx) begin
        o = 1;
        s = SAT ? mx : t % (mx + 1);
      end else begin
        s = t;
      end
    end
  endfunction

  task automatic model_update();
    bit r;
    if (reset) begin
      terms.delete();
      m_valid = 0; m_has_pend = 0; m_lost = 0; m_prev = 0;
      return;
    end
    r = mac_ready && !m_prev;
    m_prev = mac_ready;
    if (clear) begin
      terms.delete();
      m_valid = 0; m_has_pend = 0; m_lost = 0;
    end else if (!m_valid) begin
      if (r) begin
        terms.push_back(mac_out);
        if (terms.size() == LEN) m_valid = 1;
      end
    end else if (sum_ready) begin
      terms.delete();
      if (m_has_pend) terms.push_back(m_pend);
      if (r) terms.push_back(mac_out);
      m_has_pend = 0;
      m_valid = (terms.size() == LEN);
    end else if (r) begin
      if (!m_has_pend) begin
        m_has_pend = 1;
        m_pend = mac_out;
      end else begin
        m_lost = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint unsigned s;
    bit o;
    fold(12, s, o);
    chk("a_valid", valid_a, m_valid);
    chk("a_sum", sum_a, s);
    chk("a_ovf", ovf_a, o);
    chk("a_count", cnt_a, terms.size());
    chk("a_lost", lost_a, m_lost);
    fold(9, s, o);
    chk("b_valid", valid_b, m_valid);
    chk("b_sum", sum_b, s);
    chk("b_ovf", ovf_b, o);
    chk("b_count", cnt_b, terms.size());
    chk("b_lost", lost_b, m_lost);
  endtask

  task automatic step(input bit mr, input int mo, input bit clr, input bit sr, input bit rst = 0);
    mac_ready = mr;
    mac_out   = 8'(mo);
    clear     = clr;
    sum_ready = sr;
    reset     = rst;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic pulse(input int mo);
    step(1, mo, 0, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_sum", sum_a, 0);
    chk("reset_count", cnt_a, 0);
    step(0, 0, 0, 0);

    // Basic sum of four 240s
    for (int i = 0; i < 3; i++) pulse(240);
    step(1, 240, 0, 0);
    chk("basic_valid", valid_a, 1);
    chk("basic_sum", sum_a, 960);
    chk("basic_ovf", ovf_a, 0);
    chk("basic_count", cnt_a, 4);
    step(0, 0, 0, 0);

    // Backpressure: one pending, then one lost
    pulse(15);
    chk("bp_sum_held", sum_a, 960);
    chk("bp_lost0", lost_a, 0);
    pulse(7);
    chk("bp_lost1", lost_a, 1);
    step(0, 0, 0, 1);
    chk("bp_reload_count", cnt_a, 1);
    chk("bp_reload_sum", sum_a, 15);
    chk("bp_valid_drop", valid_a, 0);
    step(0, 0, 1, 0);
    chk("clear_lost", lost_a, 0);

    // Level held high counts once
    for (int i = 0; i < 20; i++) step(1, 240, 0, 0);
    chk("level_count", cnt_a, 1);
    chk("level_sum", sum_a, 240);
    step(0, 0, 0, 0);

    // Overflow on the 9-bit instance
    for (int i = 0; i < 3; i++) pulse(240);
    chk("ovf_sum_b", sum_b, SAT ? 511 : 448);
    chk("ovf_flag_b", ovf_b, 1);
    chk("ovf_sum_a", sum_a, 960);
    step(0, 0, 0, 1);
    chk("ovf_cleared_b", ovf_b, 0);

    // Rise coinciding with handshake while a result is pending
    for (int i = 0; i < 4; i++) pulse(60);
    pulse(15);
    step(1, 225, 0, 1);
    chk("simul_count", cnt_a, 2);
    chk("simul_sum", sum_a, 240);
    step(0, 0, 0, 0);

    // Clear with a coincident rise
    step(1, 99, 1, 0);
    chk("clear_count", cnt_a, 0);
    chk("clear_sum", sum_a, 0);
    step(0, 0, 0, 0);

    // Reset while holding
    for (int i = 0; i < 4; i++) pulse(100);
    chk("pre_reset_valid", valid_a, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_valid", valid_a, 0);
    chk("rst_sum", sum_a, 0);
    step(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 255),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
